// File: rtl/tracker_arb_pkg.sv
// Shared types and the round-robin pick helper for the tracker input arbiter.
package tracker_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_PAUSE = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_CHAN = 32;

    // First set bit of mask at or after ptr, scanning modulo n. Returns ptr when mask is empty.
    function automatic int unsigned rr_pick(
        input logic [MAX_CHAN-1:0] mask,
        input int unsigned         ptr,
        input int unsigned         n
    );
        int unsigned g;
        logic        found;
        g     = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_CHAN; k++) begin
            if (k < n && !found) begin
                int unsigned idx;
                idx = (ptr + k) % n;
                if (mask[idx]) begin
                    g     = idx;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/tracker_input_arbiter_sample_queue.sv
// Per-channel sample FIFO: writes only when not full, combinational read data.
module sample_queue #(
    parameter int ADDR_SIZE = 33,
    parameter int QDEPTH    = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic [ADDR_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [ADDR_SIZE-1:0] pop_data,
    output logic                 full,
    output logic                 empty
);
    localparam int PW = $clog2(QDEPTH) + 1;

    logic [ADDR_SIZE-1:0] mem [QDEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[PW-2:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PW'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PW-2:0]] <= push_data;
    end

endmodule

// File: rtl/tracker_input_arbiter.sv
// Round-robin merge of per-channel sampled read addresses onto the single tracker input port.
//   state   | meaning
//   S_IDLE  | nothing held, all queues empty
//   S_ISSUE | output held or loadable from a non-empty queue
//   S_PAUSE | tracker busy with a query, no new loads
module tracker_input_arbiter
    import tracker_arb_pkg::*;
#(
    parameter int ADDR_SIZE = 33,
    parameter int NUM_CHAN  = 2,
    parameter int QDEPTH    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_CHAN-1:0]           ch_addr_valid,
    input  logic [NUM_CHAN*ADDR_SIZE-1:0] ch_addr,
    output logic                          out_addr_valid,
    output logic [ADDR_SIZE-1:0]          out_addr,
    input  logic                          out_addr_ready,
    input  logic                          pause,
    input  logic                          clr_cnt,
    output logic [NUM_CHAN-1:0]           q_full,
    output logic [NUM_CHAN*CNT_W-1:0]     drop_cnt
);
    localparam int CW = $clog2(NUM_CHAN);

    logic [NUM_CHAN-1:0]  q_empty;
    logic [NUM_CHAN-1:0]  q_full_i;
    logic [NUM_CHAN-1:0]  pop;
    logic [ADDR_SIZE-1:0] q_data [NUM_CHAN];
    logic [CNT_W-1:0]     cnt    [NUM_CHAN];
    logic [MAX_CHAN-1:0]  mask_ext;
    logic [CW-1:0]        rr_ptr;
    logic [CW-1:0]        grant;
    logic                 any_ne;
    logic                 out_free;
    logic                 load;
    arb_state_t           state;

    assign q_full = q_full_i;

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        sample_queue #(
            .ADDR_SIZE (ADDR_SIZE),
            .QDEPTH    (QDEPTH)
        ) u_queue (
            .clk       (clk),
            .rstn      (rstn),
            .push      (ch_addr_valid[i]),
            .push_data (ch_addr[i*ADDR_SIZE +: ADDR_SIZE]),
            .pop       (pop[i]),
            .pop_data  (q_data[i]),
            .full      (q_full_i[i]),
            .empty     (q_empty[i])
        );

        // Drops are judged on the registered full flag, so a same-cycle pop does not rescue a push.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt[i] <= '0;
            end else if (clr_cnt) begin
                cnt[i] <= '0;
            end else if (ch_addr_valid[i] && q_full_i[i] && (cnt[i] != '1)) begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end

        assign drop_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

    always_comb begin
        mask_ext                 = '0;
        mask_ext[NUM_CHAN-1:0]   = ~q_empty;
        any_ne                   = |(~q_empty);
        out_free                 = !out_addr_valid || out_addr_ready;
        load                     = out_free && !pause && any_ne;
        grant                    = CW'(rr_pick(mask_ext, 32'(rr_ptr), NUM_CHAN));
        pop                      = '0;
        if (load) pop[grant]     = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_addr_valid <= 1'b0;
            out_addr       <= '0;
            rr_ptr         <= '0;
        end else if (load) begin
            out_addr_valid <= 1'b1;
            out_addr       <= q_data[grant];
            rr_ptr         <= (grant == CW'(NUM_CHAN - 1)) ? '0 : grant + CW'(1);
        end else if (out_addr_valid && out_addr_ready) begin
            out_addr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pause)       state <= S_PAUSE;
                    else if (any_ne) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (pause && out_free)        state <= S_PAUSE;
                    else if (!any_ne && out_free) state <= S_IDLE;
                end
                S_PAUSE: begin
                    // A held output still counts as work once the pause lifts.
                    if (!pause) state <= (any_ne || out_addr_valid) ? S_ISSUE : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tracker_input_arbiter.sv
// Directed self-checking bench for tracker_input_arbiter (2 channels, depth 8, 4-bit drop counters).
module tb_tracker_input_arbiter;
    localparam int AW = 33;
    localparam int NC = 2;
    localparam int QD = 8;
    localparam int CW = 4;

    logic              clk;
    logic              rstn;
    logic [NC-1:0]     ch_addr_valid;
    logic [NC*AW-1:0]  ch_addr;
    logic              out_addr_valid;
    logic [AW-1:0]     out_addr;
    logic              out_addr_ready;
    logic              pause;
    logic              clr_cnt;
    logic [NC-1:0]     q_full;
    logic [NC*CW-1:0]  drop_cnt;

    int errors;
    int checks;

    tracker_input_arbiter #(
        .ADDR_SIZE (AW),
        .NUM_CHAN  (NC),
        .QDEPTH    (QD),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ch_addr_valid  (ch_addr_valid),
        .ch_addr        (ch_addr),
        .out_addr_valid (out_addr_valid),
        .out_addr       (out_addr),
        .out_addr_ready (out_addr_ready),
        .pause          (pause),
        .clr_cnt        (clr_cnt),
        .q_full         (q_full),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn           = 1'b0;
        ch_addr_valid  = '0;
        ch_addr        = '0;
        out_addr_ready = 1'b0;
        pause          = 1'b0;
        clr_cnt        = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_addr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b want 0", out_addr_valid);
        end
        checks++;
        if (out_addr !== '0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", out_addr);
        end
        checks++;
        if (q_full !== 2'b00 || drop_cnt !== 8'h00) begin
            errors++; $display("FAIL reset_flags: q_full=%b drop_cnt=%h want 00/00", q_full, drop_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        out_addr_ready   = 1'b1;
        ch_addr_valid    = 2'b01;
        ch_addr[AW-1:0]  = 33'h1_0000_0040;
        tick();
        ch_addr_valid = 2'b00;
        checks++;
        if (out_addr_valid !== 1'b0) begin
            errors++; $display("FAIL single_edge1: valid=%0b want 0", out_addr_valid);
        end
        tick();
        checks++;
        if (out_addr_valid !== 1'b1 || out_addr !== 33'h1_0000_0040) begin
            errors++; $display("FAIL single_edge2: valid=%0b addr=%h want 1/100000040", out_addr_valid, out_addr);
        end
        tick();
        checks++;
        if (out_addr_valid !== 1'b0 || drop_cnt !== 8'h00) begin
            errors++; $display("FAIL single_edge3: valid=%0b drop=%h want 0/00", out_addr_valid, drop_cnt);
        end
    endtask

    task automatic test_alternate();
        logic [AW-1:0] exp_q [16];
        int            n;
        int            bad;
        for (int k = 0; k < 8; k++) begin
            exp_q[2*k]   = 33'h0_0000_0100 + 33'(k);
            exp_q[2*k+1] = 33'h1_0000_0200 + 33'(k);
        end
        do_reset();
        out_addr_ready = 1'b1;
        n   = 0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 8) begin
                ch_addr_valid        = 2'b11;
                ch_addr[AW-1:0]      = 33'h0_0000_0100 + 33'(c);
                ch_addr[2*AW-1:AW]   = 33'h1_0000_0200 + 33'(c);
            end else begin
                ch_addr_valid = 2'b00;
            end
            tick();
            if (out_addr_valid) begin
                if (n < 16) begin
                    checks++;
                    if (out_addr !== exp_q[n]) begin
                        errors++; bad++;
                        if (bad < 4) $display("FAIL alt_order[%0d]: got %h want %h", n, out_addr, exp_q[n]);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL alt_count: got %0d outputs want 16", n);
        end
        checks++;
        if (drop_cnt !== 8'h00) begin
            errors++; $display("FAIL alt_drops: got %h want 00", drop_cnt);
        end
    endtask

    task automatic test_fill_hold();
        int unstable;
        do_reset();
        out_addr_ready = 1'b0;
        unstable = 0;
        for (int c = 0; c < 10; c++) begin
            ch_addr_valid       = 2'b10;
            ch_addr[2*AW-1:AW]  = 33'h0_0000_1000 + 33'(c);
            tick();
            if (c >= 1 && (out_addr_valid !== 1'b1 || out_addr !== 33'h0_0000_1000)) unstable++;
            if (c == 7) begin
                checks++;
                if (q_full !== 2'b00) begin
                    errors++; $display("FAIL fill_7queued: q_full=%b want 00", q_full);
                end
            end
            if (c == 8) begin
                checks++;
                if (q_full !== 2'b10) begin
                    errors++; $display("FAIL fill_8queued: q_full=%b want 10", q_full);
                end
            end
        end
        ch_addr_valid = 2'b00;
        tick();
        checks++;
        if (unstable != 0) begin
            errors++; $display("FAIL fill_hold: %0d cycles with unstable output", unstable);
        end
        checks++;
        if (drop_cnt !== 8'h10) begin
            errors++; $display("FAIL fill_drop: drop_cnt=%h want 10", drop_cnt);
        end
    endtask

    task automatic test_pause();
        int leaked;
        do_reset();
        out_addr_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            ch_addr_valid    = 2'b01;
            ch_addr[AW-1:0]  = 33'h0_0000_00A0 + 33'(c);
            tick();
        end
        ch_addr_valid = 2'b00;
        pause = 1'b1;
        tick();
        checks++;
        if (out_addr_valid !== 1'b1 || out_addr !== 33'h0_0000_00A0) begin
            errors++; $display("FAIL pause_hold: valid=%0b addr=%h want 1/0000000a0", out_addr_valid, out_addr);
        end
        out_addr_ready = 1'b1;
        tick();
        out_addr_ready = 1'b0;
        leaked = 0;
        for (int c = 0; c < 3; c++) begin
            if (out_addr_valid !== 1'b0) leaked++;
            tick();
        end
        checks++;
        if (leaked != 0) begin
            errors++; $display("FAIL pause_block: %0d cycles valid while paused want 0", leaked);
        end
        pause = 1'b0;
        tick();
        checks++;
        if (out_addr_valid !== 1'b1 || out_addr !== 33'h0_0000_00A1) begin
            errors++; $display("FAIL pause_resume: valid=%0b addr=%h want 1/0000000a1", out_addr_valid, out_addr);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_addr_ready = 1'b0;
        // 9 accepted (1 in output + 8 queued), then 20 dropped
        for (int c = 0; c < 29; c++) begin
            ch_addr_valid    = 2'b01;
            ch_addr[AW-1:0]  = 33'h0_0000_2000 + 33'(c);
            tick();
            if (c == 22) begin
                checks++;
                if (drop_cnt[3:0] !== 4'd14) begin
                    errors++; $display("FAIL sat_14: drop_cnt0=%0d want 14", drop_cnt[3:0]);
                end
            end
        end
        checks++;
        if (drop_cnt[3:0] !== 4'd15 || q_full[0] !== 1'b1) begin
            errors++; $display("FAIL sat_15: drop_cnt0=%0d q_full0=%0b want 15/1", drop_cnt[3:0], q_full[0]);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        ch_addr_valid = 2'b00;
        checks++;
        if (drop_cnt !== 8'h00) begin
            errors++; $display("FAIL sat_clear: drop_cnt=%h want 00", drop_cnt);
        end
        ch_addr_valid = 2'b01;
        tick();
        ch_addr_valid = 2'b00;
        checks++;
        if (drop_cnt !== 8'h01) begin
            errors++; $display("FAIL sat_after_clear: drop_cnt=%h want 01", drop_cnt);
        end
    endtask

    task automatic test_async_reset();
        int stale;
        do_reset();
        out_addr_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            ch_addr_valid    = 2'b01;
            ch_addr[AW-1:0]  = 33'h1_0000_3000 + 33'(c);
            tick();
        end
        ch_addr_valid = 2'b00;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_addr_valid !== 1'b0 || out_addr !== '0 || q_full !== 2'b00) begin
            errors++; $display("FAIL async_rst: valid=%0b addr=%h q_full=%b want 0/0/00", out_addr_valid, out_addr, q_full);
        end
        tick();
        rstn = 1'b1;
        out_addr_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_addr_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++; $display("FAIL async_stale: %0d cycles with valid after reset want 0", stale);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_alternate();
        test_fill_hold();
        test_pause();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
